uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer between the rx deserializer and interface_circuit.
//  It captures one byte per rising edge of the rx done strobe.
//  It holds up to 2**DEPTH_LOG2 bytes and presents the oldest byte first-word-fall-through.
//  The consumer pops with a one-cycle read request, so back-to-back UART frames are not lost
//  while the consumer is busy driving the ALU/tx path.
// PARAMETERS
//  WIDTH_WORD   8   data width in bits; equals the rx word width
//  DEPTH_LOG2   4   log2 of entry count (default depth 16)
// PORTS
//  i_clock           in   1               system clock; all logic on its rising edge
//  i_reset           in   1               asynchronous, active-low reset
//  i_wr              in   1               rx done strobe (o_rx_done of rx); writes on rising edge
//  i_data_wr         in   WIDTH_WORD      rx data byte, sampled on the cycle i_wr rises
//  i_rd              in   1               pop request; one pop per cycle asserted while not empty
//  i_clr_overflow    in   1               clears sticky o_overflow
//  o_data_rd         out  WIDTH_WORD      oldest stored byte (FWFT); 0 when empty
//  o_empty           out  1               no entries stored
//  o_full            out  1               2**DEPTH_LOG2 entries stored
//  o_count           out  DEPTH_LOG2+1    number of stored entries, 0..2**DEPTH_LOG2
//  o_overflow        out  1               sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (i_reset=0, async):
//   - wr_ptr=0, rd_ptr=0, o_count=0, o_empty=1, o_full=0, o_overflow=0.
//   - i_wr edge register = 1, so a strobe already high at reset release is not a write.
//   - Storage array is not reset.
//  Write event (wr_ev):
//   - Defined as i_wr=1 and i_wr_q=0, where i_wr_q is i_wr registered.
//   - Exactly one write per strobe assertion, whatever its length.
//  Read event (rd_ev): i_rd=1 and o_empty=0. i_rd while empty is ignored; no state change.
//  Accepted write (accepted_wr): wr_ev and (!o_full or rd_ev).
//   - On the next edge: mem[wr_ptr] <= i_data_wr; wr_ptr <= wr_ptr+1.
//  Accepted read: on the next edge rd_ptr <= rd_ptr+1.
//  Pointers:
//   - Width DEPTH_LOG2; wrap 2**DEPTH_LOG2-1 -> 0 naturally.
//   - o_count tracks occupancy explicitly.
//  o_count <= o_count + accepted_wr - rd_ev.
//   - o_empty = (o_count==0); o_full = (o_count==2**DEPTH_LOG2).
//   - Both are registered/derived from o_count, never from a pointer compare.
//  o_data_rd:
//   - Combinational mem[rd_ptr] when !o_empty, else 0.
//   - A written byte is visible the cycle after its write edge. Latency write->o_data_rd = 1 clk.
//  Simultaneous events:
//   - Full and wr_ev and rd_ev: both accepted, o_count unchanged, o_overflow unchanged.
//   - Empty and wr_ev and i_rd: write accepted, read ignored, o_count -> 1.
//   - Otherwise wr_ev and rd_ev: both accepted, count unchanged.
//  Overflow:
//   - Full and wr_ev and !rd_ev: byte dropped; o_overflow <= 1 next edge; contents unchanged.
//   - i_clr_overflow=1 clears o_overflow next edge.
//   - If clear and a new drop occur in the same cycle, the drop wins (o_overflow=1).
//  Reset mid-operation: immediate return to reset state; stored bytes are discarded
//   (o_empty=1 asynchronously).
//  No combinational path from i_rd/i_wr to o_empty/o_full/o_count.
// TESTING
//  1 Reset:
//    - i_reset low with i_wr=1 held through release -> no write.
//    - o_empty=1, o_count=0, o_data_rd=0.
//  2 Strobe length:
//    - Strobe held 5 cycles with data 0xA5 -> exactly one entry; o_count=1.
//    - o_data_rd=0xA5 one cycle after the rising edge.
//  3 Order:
//    - Write 0x01..0x10 (16 strobes) -> o_full=1, o_count=16.
//    - Pop 16 times -> 0x01..0x10 in order; then o_empty=1.
//    - Repeat once more to cover pointer wrap.
//  4 Overflow:
//    - Fill 16, then strobe 0xEE -> o_overflow=1; o_count stays 16; reads still return 0x01..0x10.
//    - Pulse i_clr_overflow -> o_overflow=0.
//  5 Simultaneous events:
//    - Full + strobe 0x77 + i_rd in the same cycle -> 0x01 popped, 0x77 stored last, o_overflow=0.
//    - Empty + strobe 0x33 + i_rd -> o_count=1, o_data_rd=0x33.
//  6 Async reset:
//    - Assert i_reset mid-fill (o_count=7) between clock edges -> outputs reach reset values
//      without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer between the UART rx deserializer and the
//   interface circuit. One byte is captured per rising edge of the rx done
//   strobe, and the oldest stored byte is shown first-word-fall-through. The
//   consumer removes it with a single-cycle read request. Back-to-back frames
//   are therefore kept while the consumer is busy with the ALU/tx path.
//
// Parameters
//   WIDTH_WORD      data width in bits (rx word width)
//   DEPTH_LOG2      log2 of the entry count
//
// Ports
//   i_clock         system clock, rising edge
//   i_reset         asynchronous, active-low reset
//   i_wr            rx done strobe; its rising edge writes i_data_wr
//   i_data_wr       byte to store, sampled on the cycle i_wr rises
//   i_rd            pop request; pops one entry per cycle while not empty
//   i_clr_overflow  clears the sticky overflow flag
//   o_data_rd       oldest stored byte, 0 when empty
//   o_empty         no entries stored
//   o_full          2**DEPTH_LOG2 entries stored
//   o_count         number of stored entries
//   o_overflow      sticky: a write was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH_WORD = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic [WIDTH_WORD-1:0] i_data_wr,
    input  logic                  i_rd,
    input  logic                  i_clr_overflow,
    output logic [WIDTH_WORD-1:0] o_data_rd,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH_WORD-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  wr_q;
    logic                  overflow;

    logic wr_ev;
    logic rd_ev;
    logic accepted_wr;
    logic drop_wr;

    // A long strobe writes once: only its first cycle counts as an event.
    assign wr_ev       = i_wr & ~wr_q;
    assign rd_ev       = i_rd & ~o_empty;
    // When full, a simultaneous pop frees the slot the write needs.
    assign accepted_wr = wr_ev & (~o_full | rd_ev);
    assign drop_wr     = wr_ev & o_full & ~rd_ev;

    // Status flags come only from the registered count. This keeps i_rd/i_wr
    // out of any combinational path to them, and the async reset clears them
    // immediately.
    assign o_count    = count;
    assign o_empty    = (count == '0);
    assign o_full     = (count == FULL_COUNT);
    assign o_overflow = overflow;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            // Starts high so that a strobe already asserted at reset release
            // is not seen as a rising edge.
            wr_q     <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments. All of them
            // then update together from the same pre-edge values, with no
            // dependence on statement order.
            wr_q <= i_wr;
            if (accepted_wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ev)       rd_ptr <= rd_ptr + 1'b1;

            case ({accepted_wr, rd_ev})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_wr)             overflow <= 1'b1;
            else if (i_clr_overflow) overflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset. Emptiness is tracked by count
    // alone, so old contents are never visible, and leaving out the reset
    // lets the array map onto plain RAM.
    always_ff @(posedge i_clock) begin
        if (accepted_wr) mem[wr_ptr] <= i_data_wr;
    end

    // NOTE: the combinational output gets a default assignment first. Every
    // path then assigns it, and no latch is inferred.
    always_comb begin
        o_data_rd = '0;
        if (!o_empty) o_data_rd = mem[rd_ptr];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. Stimulus pushes each byte it expects the
//   FIFO to accept into a scoreboard queue. A monitor compares o_data_rd
//   against the queue head on every cycle in which a pop takes place.
//   Status outputs are checked at fixed points with hand-derived values.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int W  = 8;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_wr;
    logic [W-1:0]  i_data_wr;
    logic          i_rd;
    logic          i_clr_overflow;
    logic [W-1:0]  o_data_rd;
    logic          o_empty;
    logic          o_full;
    logic [DL:0]   o_count;
    logic          o_overflow;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.WIDTH_WORD(W), .DEPTH_LOG2(DL)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_wr           (i_wr),
        .i_data_wr      (i_data_wr),
        .i_rd           (i_rd),
        .i_clr_overflow (i_clr_overflow),
        .o_data_rd      (o_data_rd),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_count        (o_count),
        .o_overflow     (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop happens on any cycle with i_rd high and o_empty low.
    // Sampling on the falling edge avoids races with the driving tasks.
    always @(negedge clk) begin
        if (i_reset && i_rd && !o_empty) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", o_data_rd, $time);
            end else begin
                check("pop_data", 32'(o_data_rd), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the strobe high for len cycles, then low for one cycle.
    task automatic strobe(input logic [W-1:0] d, input int len, input bit accept);
        i_wr      = 1'b1;
        i_data_wr = d;
        if (accept) exp_q.push_back(d);
        repeat (len) tick();
        i_wr = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        i_rd = 1'b1;
        repeat (n) tick();
        i_rd = 1'b0;
    endtask

    task automatic fill_seq(input int first);
        for (int k = 0; k < 16; k++) strobe(W'(first + k), 1, 1'b1);
    endtask

    initial begin
        i_reset        = 1'b0;
        i_wr           = 1'b1;
        i_data_wr      = 8'h5A;
        i_rd           = 1'b0;
        i_clr_overflow = 1'b0;

        // 1: a strobe held high through reset release must not write.
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b1;
        repeat (3) tick();
        check("rst_count", 32'(o_count), 0);
        check("rst_empty", 32'(o_empty), 1);
        check("rst_full",  32'(o_full), 0);
        check("rst_data",  32'(o_data_rd), 0);
        check("rst_ovf",   32'(o_overflow), 0);
        i_wr = 1'b0;
        tick();
        check("rst_no_write", 32'(o_count), 0);

        // 2: a 5-cycle strobe stores one byte, visible one cycle after the edge.
        i_wr      = 1'b1;
        i_data_wr = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        check("len_data_lat1", 32'(o_data_rd), 32'h0A5);
        check("len_count_lat1", 32'(o_count), 1);
        repeat (4) tick();
        check("len_count_held", 32'(o_count), 1);
        i_wr = 1'b0;
        tick();
        check("len_count_end", 32'(o_count), 1);
        pop_n(1);
        check("len_empty_after_pop", 32'(o_empty), 1);

        // 3: order and pointer wrap, two full passes.
        for (int pass = 0; pass < 2; pass++) begin
            fill_seq(1);
            check("ord_full",  32'(o_full), 1);
            check("ord_count", 32'(o_count), 16);
            pop_n(16);
            check("ord_empty", 32'(o_empty), 1);
            check("ord_data0", 32'(o_data_rd), 0);
        end

        // 4: a write while full is dropped and sets the sticky flag.
        fill_seq(1);
        strobe(8'hEE, 1, 1'b0);
        check("ovf_flag",  32'(o_overflow), 1);
        check("ovf_count", 32'(o_count), 16);
        check("ovf_head",  32'(o_data_rd), 32'h01);
        pop_n(16);
        check("ovf_sticky", 32'(o_overflow), 1);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 0);

        // 5a: full + write + pop in one cycle, so both are accepted.
        fill_seq(1);
        i_wr      = 1'b1;
        i_data_wr = 8'h77;
        i_rd      = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        i_wr = 1'b0;
        i_rd = 1'b0;
        check("sim_full_count", 32'(o_count), 16);
        check("sim_full_head",  32'(o_data_rd), 32'h02);
        check("sim_full_ovf",   32'(o_overflow), 0);
        tick();
        pop_n(16);
        check("sim_full_drain", 32'(o_empty), 1);

        // 5b: empty + write + pop, so the write is accepted and the pop ignored.
        i_wr      = 1'b1;
        i_data_wr = 8'h33;
        i_rd      = 1'b1;
        exp_q.push_back(8'h33);
        tick();
        i_rd = 1'b0;
        i_wr = 1'b0;
        check("sim_empty_count", 32'(o_count), 1);
        check("sim_empty_data",  32'(o_data_rd), 32'h33);
        tick();
        pop_n(1);

        // 6: async reset mid-fill clears outputs without a clock edge.
        for (int k = 0; k < 7; k++) strobe(W'(8'h40 + k), 1, 1'b0);
        check("arst_pre_count", 32'(o_count), 7);
        #2 i_reset = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 0);
        check("arst_empty", 32'(o_empty), 1);
        check("arst_full",  32'(o_full), 0);
        check("arst_data",  32'(o_data_rd), 0);
        tick();
        i_reset = 1'b1;
        tick();
        check("arst_after_count", 32'(o_count), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
